life_cell_step: RTL
===================

# life_cell_step

Serial next-state engine for one Game of Life cell. It accepts a cell's current state and its 8 neighbour bits over a valid/ready handshake and counts live neighbours one bit per cycle into an accumulator built on `adder_n`. It applies the birth/survival rule and returns the next cell state and the neighbour count over a second valid/ready handshake. It sits directly downstream of `adder_n`, which it instantiates as its accumulator datapath, and upstream of the grid write-back logic.

## Interface
- `N`, 4, accumulator/count width; must be ≥ 4 so that a count of 8 is representable.
- `BIRTH_MASK`, 9'b0_0000_1000, bit k set means a dead cell with k live neighbours becomes alive (B3).
- `SURVIVE_MASK`, 9'b0_0000_1100, bit k set means a live cell with k live neighbours stays alive (S23).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream offers a cell.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `cell_alive`  in  1  current state of the cell.
- `neighbors`  in  8  neighbour bits; bit 0 is counted first.
- `out_valid`  out  1  result available; high only in RESULT.
- `out_ready`  in  1  downstream accepts the result.
- `next_alive`  out  1  next cell state; valid while `out_valid` is high.
- `count`  out  N  live-neighbour count, 0..8; valid while `out_valid` is high.

## Operation
- States: IDLE, COUNT, RESULT.
- IDLE: `in_ready`=1. On `in_valid & in_ready`, capture `cell_alive` into `alive_q` and `neighbors` into `nbr_q`. Then clear `acc` to 0 and `idx` (3 bits) to 0, and go to COUNT.
- COUNT: `in_ready`=0 and `out_valid`=0.
  - Each cycle, `acc <= sum` from `adder_n`, with a=`acc`, b=0, c_in=`nbr_q[idx]`. Then `idx <= idx+1`.
  - When `idx`==7, the add completes and the state goes to RESULT.
  - `c_out` must never be 1 (max count 8 < 2^N). Add a simulation assertion for this.
- RESULT: `out_valid`=1 and `count`=`acc`.
  - `next_alive` = `alive_q ? SURVIVE_MASK[acc] : BIRTH_MASK[acc]`. This is combinational from registers and stable while in RESULT.
  - On `out_valid & out_ready`, go to IDLE.
  - Outputs must hold unchanged while `out_ready`=0, for any number of cycles.
- Inputs other than `out_ready` are ignored outside IDLE. `in_valid` may stay high across a transaction and is not re-sampled until IDLE.
- `count`/`next_alive` are don't-care when `out_valid`=0. The implementation drives `acc`/rule value; the bench must not check them.

## Timing
- Reset (async assert; release synchronised by the system): state=IDLE, `acc`=0, `idx`=0, `alive_q`=0, `nbr_q`=0.
  - Outputs during and after reset: `out_valid`=0, `in_ready`=1, `count`=0, `next_alive`=BIRTH_MASK[0].
- Latency: input handshake at edge E gives `out_valid` high after edge E+8. That is 1 capture edge plus 8 count edges, so `out_valid` is high in the 9th cycle after the handshake cycle.
- Output handshake at edge F gives IDLE after F, with `in_ready`=1 in the next cycle. Best-case throughput is 1 cell per 10 cycles. There is no overlap of input accept with RESULT.
- Reset mid-COUNT or mid-RESULT: the transaction is discarded with no output. The block returns to its reset values immediately on `rst_n` falling.
- `out_ready` high before RESULT has no effect.

## Structure
- Shared package `life_pkg`:
  - `typedef enum logic [1:0] {IDLE, COUNT, RESULT} step_state_t`
  - `localparam MAX_NEIGHBORS = 8`
  - `DEFAULT_BIRTH_MASK` and `DEFAULT_SURVIVE_MASK`, which the module defaults reference.
- One sub-module: `adder_n #(.N(N))` as the accumulator adder. No other arithmetic in the block.
- Single `always_ff` for state/registers and `always_comb` for next-state and outputs.

## Test plan
- Reset, then idle: `in_ready`=1, `out_valid`=0 immediately after `rst_n` release. With `in_valid`=0 for 20 cycles, `out_valid` stays 0.
- `cell_alive`=0, `neighbors`=8'b0000_0111: `out_valid` rises exactly 9 cycles after the handshake, with `count`=3 and `next_alive`=1 (birth).
- Survival and death:
  - `cell_alive`=1, `neighbors`=8'b1000_0001 gives `count`=2, `next_alive`=1.
  - `cell_alive`=1, `neighbors`=8'b1111_0000 gives `count`=4, `next_alive`=0.
  - `cell_alive`=1, `neighbors`=8'h00 gives `count`=0, `next_alive`=0.
- Full neighbourhood and backpressure: `cell_alive`=0, `neighbors`=8'hFF gives `count`=8 and `next_alive`=0. With `out_ready` held low for 5 cycles, outputs stay unchanged and `in_ready`=0. `out_ready`=1 then gives IDLE next cycle.
- Back-to-back with `in_valid` held high and `out_ready`=1: two cells are accepted 10 cycles apart. Changing `neighbors` during COUNT does not affect `count`.
- Reset mid-COUNT: assert `rst_n`=0 four cycles after the handshake. `out_valid` stays 0 and the block is in IDLE with `count`=0. A fresh transaction afterwards gives the correct result.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life cell engines.
package life_pkg;

   typedef enum logic [1:0] {IDLE, COUNT, RESULT} step_state_t;

   localparam int MAX_NEIGHBORS = 8;

   // B3/S23: bit k set means k live neighbours produce a live cell.
   localparam logic [8:0] DEFAULT_BIRTH_MASK   = 9'b0_0000_1000;
   localparam logic [8:0] DEFAULT_SURVIVE_MASK = 9'b0_0000_1100;

endpackage

// File: rtl/adder_n.sv
// N-bit ripple adder with carry in/out, used as the neighbour-count accumulator datapath.
module adder_n #(
   parameter int N = 4
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_c_in,
   output logic [N-1:0] o_sum,
   output logic         o_c_out
);

   assign {o_c_out, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_c_in};

endmodule

// File: rtl/life_cell_step.sv
// Serial next-state engine for one Game of Life cell: counts one neighbour bit per
// cycle through adder_n, then applies the birth/survival masks.
module life_cell_step
   import life_pkg::*;
#(
   parameter int         N            = 4,
   parameter logic [8:0] BIRTH_MASK   = DEFAULT_BIRTH_MASK,
   parameter logic [8:0] SURVIVE_MASK = DEFAULT_SURVIVE_MASK
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic         i_cell_alive,
   input  logic [7:0]   i_neighbors,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic         o_next_alive,
   output logic [N-1:0] o_count
);

   step_state_t  r_state;
   logic [N-1:0] r_acc;
   logic [2:0]   r_idx;
   logic         r_alive;
   logic [7:0]   r_nbr;

   step_state_t  w_state_next;
   logic [N-1:0] w_acc_next;
   logic [2:0]   w_idx_next;
   logic         w_alive_next;
   logic [7:0]   w_nbr_next;
   logic [N-1:0] w_sum;
   logic         w_c_out;
   logic [8:0]   w_rule_mask;

   adder_n #(.N(N)) u_acc_adder (
      .i_a    (r_acc),
      .i_b    ({N{1'b0}}),
      .i_c_in (r_nbr[r_idx]),
      .o_sum  (w_sum),
      .o_c_out(w_c_out)
   );

   always_comb begin
      w_state_next = r_state;
      w_acc_next   = r_acc;
      w_idx_next   = r_idx;
      w_alive_next = r_alive;
      w_nbr_next   = r_nbr;
      case (r_state)
         IDLE: begin
            if (i_in_valid) begin
               w_alive_next = i_cell_alive;
               w_nbr_next   = i_neighbors;
               w_acc_next   = '0;
               w_idx_next   = '0;
               w_state_next = COUNT;
            end
         end
         COUNT: begin
            w_acc_next = w_sum;
            w_idx_next = r_idx + 3'd1;
            if (r_idx == 3'd7) begin
               w_state_next = RESULT;
            end
         end
         RESULT: begin
            if (i_out_ready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase

      // Counts above MAX_NEIGHBORS cannot occur; guard keeps the mask select in range.
      w_rule_mask  = r_alive ? SURVIVE_MASK : BIRTH_MASK;
      o_next_alive = (r_acc <= N'(MAX_NEIGHBORS)) && w_rule_mask[r_acc[3:0]];
      o_count      = r_acc;
      o_in_ready   = (r_state == IDLE);
      o_out_valid  = (r_state == RESULT);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_idx   <= '0;
         r_alive <= 1'b0;
         r_nbr   <= '0;
      end else begin
         r_state <= w_state_next;
         r_acc   <= w_acc_next;
         r_idx   <= w_idx_next;
         r_alive <= w_alive_next;
         r_nbr   <= w_nbr_next;
      end
   end

   // A full neighbourhood of 8 fits in N >= 4 bits, so the accumulator never carries out.
   always_comb begin
      if (r_state == COUNT) begin
         assert (!w_c_out);
      end
   end

endmodule
